// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing-error flag
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, byte_n;
  logic dv_n, fe_n;
  // two-flop synchroniser, reset to the idle-high line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_serial;
      rx_s <= rx_m;
    end
  end
  // state, counters, shift register and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_byte   <= '0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      rx_byte   <= byte_n;
      rx_dv     <= dv_n;
      frame_err <= fe_n;
    end
  end
  // next-state: wait half a bit to confirm the start, then sample each bit one bit-time later
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    idx_n     = idx;
    sh_n      = sh;
    byte_n    = rx_byte;
    dv_n      = 1'b0;
    fe_n      = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        clk_cnt_n = clk_cnt + 1'b1;
        if (clk_cnt == HALF) begin
          clk_cnt_n = '0;
          idx_n     = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        clk_cnt_n = clk_cnt + 1'b1;
        if (clk_cnt == LAST) begin
          clk_cnt_n = '0;
          sh_n[idx] = rx_s;
          idx_n     = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        clk_cnt_n = clk_cnt + 1'b1;
        if (clk_cnt == LAST) begin
          clk_cnt_n = '0;
          byte_n    = rx_s ? sh : rx_byte;
          dv_n      = rx_s;
          fe_n      = !rx_s;
          state_n   = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        clk_cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed and random 8N1 frames checked against a frame-level receive model
module tb_uart_rx_byte;
  localparam int CPB = 8;
  localparam int HALF = (CPB - 1) / 2;
  logic clk, rst, rx_serial, rx_dv, frame_err, busy;
  logic [7:0] rx_byte;
  int n_chk, n_err;
  logic [7:0] got_q[$];
  int dv_cyc[$];
  int cyc, fe_cnt, both_cnt, unstable;
  logic [7:0] prev_byte;
  logic [7:0] exp_q[$];
  logic [7:0] exp_last;
  int exp_fe, rd;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial), .rx_dv(rx_dv),
    .rx_byte(rx_byte), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observe strobes just after each active edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rx_dv) begin
      got_q.push_back(rx_byte);
      dv_cyc.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (rx_dv && frame_err) both_cnt++;
    if (!rst && !rx_dv && rx_byte !== prev_byte) unstable++;
    prev_byte = rx_byte;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx_serial = 1'b0;
    clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      clks(CPB);
    end
    rx_serial = stop;
    clks(CPB);
    if (stop) begin
      exp_q.push_back(b);
      exp_last = b;
    end else exp_fe++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = got_q.size() - rd;
    check({tag, "_ndv"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) check({tag, "_byte"}, got_q[rd + i], exp_q[i]);
    check({tag, "_fe"}, fe_cnt, exp_fe);
    check({tag, "_last"}, rx_byte, exp_last);
    check({tag, "_busy"}, busy, 0);
    rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    int base, gap;
    logic [7:0] b;
    logic stop;
    rst = 1'b1;
    rx_serial = 1'b1;
    exp_last = 8'h00;
    clks(3);
    check("rst_dv", rx_dv, 0);
    check("rst_byte", rx_byte, 8'h00);
    check("rst_fe", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    clks(2 * CPB);
    send(8'h0D, 1'b1);
    rx_serial = 1'b1;
    clks(2 * CPB);
    drain("b0d");
    rx_serial = 1'b0;
    clks(2);
    rx_serial = 1'b1;
    clks(2);
    check("glitch_busy_hi", busy, 1);
    clks(HALF + 1);
    check("glitch_busy_lo", busy, 0);
    clks(2 * CPB);
    drain("glitch");
    send(8'h41, 1'b0);
    rx_serial = 1'b1;
    clks(2 * CPB);
    drain("ferr");
    base = got_q.size();
    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    rx_serial = 1'b1;
    clks(2 * CPB);
    if (got_q.size() >= base + 2) check("b2b_gap", dv_cyc[base + 1] - dv_cyc[base], 10 * CPB);
    else check("b2b_cnt", got_q.size() - base, 2);
    drain("b2b");
    rx_serial = 1'b0;
    clks(CPB);
    rx_serial = 1'b1;
    clks(4 * CPB + CPB / 2);
    rst = 1'b1;
    #1;
    check("mid_rst_byte", rx_byte, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dv", rx_dv, 0);
    check("mid_rst_fe", frame_err, 0);
    exp_last = 8'h00;
    clks(2);
    rst = 1'b0;
    clks(5 * CPB);
    drain("mid_rst");
    send(8'h35, 1'b1);
    rx_serial = 1'b1;
    clks(2 * CPB);
    drain("b35");
    rx_serial = 1'b0;
    clks(40 * CPB);
    exp_fe++;
    rx_serial = 1'b1;
    clks(2 * CPB);
    send(8'h7A, 1'b1);
    rx_serial = 1'b1;
    clks(2 * CPB);
    drain("brk");
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send(b, stop);
      rx_serial = 1'b1;
      gap = stop ? $urandom_range(0, 2 * CPB) : $urandom_range(CPB, 3 * CPB);
      clks(gap);
    end
    rx_serial = 1'b1;
    clks(2 * CPB);
    drain("rand");
    check("dv_fe_overlap", both_cnt, 0);
    check("byte_stable", unstable, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
